// File: rtl/clock_set_buttons_pkg.sv
// Shared types and 50 MHz default timing constants for the clock's
// button conditioning block.
package clock_set_buttons_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYC = 500000;
  localparam int DEF_HOLD_CYC     = 25000000;
  localparam int DEF_REPEAT_CYC   = 5000000;

  // Counter width able to hold 0 .. max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clock_set_buttons_if.sv
// Raw button/switch pins in, conditioned increment pulses and run level out.
interface clock_set_buttons_if;
  logic hrup;
  logic minup;
  logic secup;
  logic en;
  logic hr_inc;
  logic min_inc;
  logic sec_inc;
  logic run;

  modport master (
    output hrup, minup, secup, en,
    input  hr_inc, min_inc, sec_inc, run
  );

  modport slave (
    input  hrup, minup, secup, en,
    output hr_inc, min_inc, sec_inc, run
  );
endinterface

// File: rtl/btn_debounce_repeat.sv
// One input channel: 2-flop synchroniser, debouncer and, optionally, the
// press / hold / auto-repeat pulse generator.
module btn_debounce_repeat
  import clock_set_buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit USE_FSM      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic mute,
  output logic level,
  output logic pulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYC, 1);
  localparam int HW = cnt_width(HOLD_CYC, REPEAT_CYC);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);

  logic [1:0]    sync;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  btn_state_t    state;
  logic          active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // level only flips after DEBOUNCE_CYC consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync[1] == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      level  <= ~level;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  // In debounce-only mode the FSM never leaves IDLE and folds away.
  assign active = USE_FSM & level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      pulse    <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (active) begin
            state    <= HELD;
            hold_cnt <= '0;
            pulse    <= ~mute;
          end
        end
        HELD: begin
          if (!active) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= REPEAT;
            hold_cnt <= '0;
            pulse    <= ~mute;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        REPEAT: begin
          if (!active) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == REP_LAST) begin
            hold_cnt <= '0;
            pulse    <= ~mute;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clock_set_buttons.sv
// Conditions the three set buttons and the run switch; increment pulses are
// only passed through in set mode (run low).
module clock_set_buttons
  import clock_set_buttons_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input logic clk,
  input logic reset,
  clock_set_buttons_if.slave bus
);

  logic [2:0] raw;
  logic [2:0] level;
  logic [2:0] pulse;
  logic [2:0] mute;
  logic [2:0] masked;
  logic       run_level;
  logic       en_pulse_unused;

  assign raw = {bus.secup, bus.minup, bus.hrup};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce_repeat #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .USE_FSM     (1'b1)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .mute (mute[i]),
      .level(level[i]),
      .pulse(pulse[i])
    );
  end

  btn_debounce_repeat #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .REPEAT_CYC  (REPEAT_CYC),
    .USE_FSM     (1'b0)
  ) u_en (
    .clk  (clk),
    .reset(reset),
    .raw  (bus.en),
    .mute (1'b0),
    .level(run_level),
    .pulse(en_pulse_unused)
  );

  // A press that overlapped run=1 stays silenced until the button is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      masked <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (run_level) begin
          masked[i] <= 1'b1;
        end else if (!level[i]) begin
          masked[i] <= 1'b0;
        end
      end
    end
  end

  assign mute = {3{run_level}} | masked;

  assign bus.hr_inc  = pulse[0];
  assign bus.min_inc = pulse[1];
  assign bus.sec_inc = pulse[2];
  assign bus.run     = run_level;

endmodule

// File: tb/tb_clock_set_buttons.sv
// Directed scenarios plus a random phase, checked every cycle against a
// timing model built from press age and debounce rules.
module tb_clock_set_buttons;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clock_set_buttons_if bus ();

  clock_set_buttons #(
    .DEBOUNCE_CYC(D),
    .HOLD_CYC    (H),
    .REPEAT_CYC  (R)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;
  int r0;
  int hr_times[$];
  int min_times[$];
  int sec_times[$];
  int exp_rel[$];

  // Model state, index 0=hr 1=min 2=sec 3=en.
  bit m_s1[4];
  bit m_s2[4];
  bit m_db[4];
  int m_dis[4];
  int m_age[3];
  bit m_taint[3];
  bit m_pulse[3];

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic checkValue(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One rising edge of the spec's behaviour: press age decides pulses, a
  // level change is accepted after D consecutive disagreeing samples.
  task automatic modelStep();
    logic [3:0] rawv;
    bit run_pre;
    bit quiet;
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        m_s1[j] = 0; m_s2[j] = 0; m_db[j] = 0; m_dis[j] = 0;
      end
      for (int i = 0; i < 3; i++) begin
        m_age[i] = -1; m_taint[i] = 0; m_pulse[i] = 0;
      end
      return;
    end
    rawv    = {bus.en, bus.secup, bus.minup, bus.hrup};
    run_pre = m_db[3];
    for (int i = 0; i < 3; i++) begin
      quiet      = run_pre || m_taint[i];
      m_pulse[i] = 0;
      if (m_age[i] < 0) begin
        if (m_db[i]) begin
          m_age[i]   = 0;
          m_pulse[i] = !quiet;
        end
      end else if (!m_db[i]) begin
        m_age[i] = -1;
      end else begin
        m_age[i]++;
        if (m_age[i] == H || (m_age[i] > H && (m_age[i] - H) % R == 0))
          m_pulse[i] = !quiet;
      end
      if (run_pre) m_taint[i] = 1;
      else if (!m_db[i]) m_taint[i] = 0;
    end
    for (int j = 0; j < 4; j++) begin
      m_dis[j] = (m_s2[j] != m_db[j]) ? m_dis[j] + 1 : 0;
      if (m_dis[j] == D) begin
        m_db[j]  = !m_db[j];
        m_dis[j] = 0;
      end
      m_s2[j] = m_s1[j];
      m_s1[j] = rawv[j];
    end
  endtask

  always @(posedge clk or posedge reset) modelStep();

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    checkOutput("hr_inc", bus.hr_inc, m_pulse[0]);
    checkOutput("min_inc", bus.min_inc, m_pulse[1]);
    checkOutput("sec_inc", bus.sec_inc, m_pulse[2]);
    checkOutput("run", bus.run, m_db[3]);
    if (bus.hr_inc === 1'b1) hr_times.push_back(cyc);
    if (bus.min_inc === 1'b1) min_times.push_back(cyc);
    if (bus.sec_inc === 1'b1) sec_times.push_back(cyc);
  end

  task automatic applyStimulus(input bit h, input bit m, input bit s, input bit e);
    @(posedge clk);
    #2;
    bus.hrup  = h;
    bus.minup = m;
    bus.secup = s;
    bus.en    = e;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clearLogs();
    hr_times.delete();
    min_times.delete();
    sec_times.delete();
  endtask

  initial begin
    reset     = 1'b1;
    bus.hrup  = 1'b0;
    bus.minup = 1'b0;
    bus.secup = 1'b0;
    bus.en    = 1'b0;
    waitCycles(3);
    checkOutput("rst_hr", bus.hr_inc, 1'b0);
    checkOutput("rst_min", bus.min_inc, 1'b0);
    checkOutput("rst_sec", bus.sec_inc, 1'b0);
    checkOutput("rst_run", bus.run, 1'b0);
    reset = 1'b0;
    waitCycles(5);

    $display("[TB] single press");
    clearLogs();
    applyStimulus(1, 0, 0, 0);
    c0 = cyc;
    waitCycles(9);
    applyStimulus(0, 0, 0, 0);
    waitCycles(20);
    checkValue("single_count", hr_times.size(), 1);
    checkValue("single_latency", (hr_times.size() > 0) ? hr_times[0] - c0 : -1, D + 3);

    $display("[TB] bounce rejection");
    clearLogs();
    for (int k = 0; k < 30; k++) applyStimulus(0, 0, ((k / 2) % 2) == 0, 0);
    applyStimulus(0, 0, 0, 0);
    waitCycles(20);
    checkValue("bounce_count", sec_times.size(), 0);

    $display("[TB] auto-repeat");
    clearLogs();
    applyStimulus(0, 1, 0, 0);
    c0 = cyc;
    waitCycles(59);
    applyStimulus(0, 0, 0, 0);
    waitCycles(30);
    // db stays high until D+2 edges after the raw fall at relative edge 60
    exp_rel.delete();
    exp_rel.push_back(D + 3);
    for (int t = D + 3 + H; t <= 60 + D + 2; t += R) exp_rel.push_back(t);
    checkValue("repeat_count", min_times.size(), exp_rel.size());
    foreach (exp_rel[i])
      checkValue($sformatf("repeat_time%0d", i),
                 (i < min_times.size()) ? min_times[i] - c0 : -1, exp_rel[i]);

    $display("[TB] run gating");
    clearLogs();
    applyStimulus(0, 0, 0, 1);
    waitCycles(12);
    checkOutput("gate_run_high", bus.run, 1'b1);
    applyStimulus(1, 0, 0, 1);
    waitCycles(12);
    applyStimulus(1, 0, 0, 0);
    waitCycles(30);
    applyStimulus(0, 0, 0, 0);
    waitCycles(12);
    checkValue("gate_masked_count", hr_times.size(), 0);
    checkOutput("gate_run_low", bus.run, 1'b0);
    applyStimulus(1, 0, 0, 0);
    c0 = cyc;
    waitCycles(9);
    applyStimulus(0, 0, 0, 0);
    waitCycles(12);
    checkValue("gate_resume_count", hr_times.size(), 1);
    checkValue("gate_resume_latency", (hr_times.size() > 0) ? hr_times[0] - c0 : -1, D + 3);

    $display("[TB] simultaneous buttons and async clear");
    clearLogs();
    applyStimulus(1, 1, 1, 0);
    c0 = cyc;
    waitCycles(D + 3);
    checkOutput("simul_hr", bus.hr_inc, 1'b1);
    checkOutput("simul_min", bus.min_inc, 1'b1);
    checkOutput("simul_sec", bus.sec_inc, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("async_hr", bus.hr_inc, 1'b0);
    checkOutput("async_min", bus.min_inc, 1'b0);
    checkOutput("async_sec", bus.sec_inc, 1'b0);
    bus.hrup  = 1'b0;
    bus.minup = 1'b0;
    bus.secup = 1'b0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(20);

    $display("[TB] mid-operation reset");
    clearLogs();
    applyStimulus(0, 1, 0, 0);
    c0 = cyc;
    waitCycles(25);
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    r0 = cyc;
    waitCycles(9);
    applyStimulus(0, 0, 0, 0);
    waitCycles(20);
    checkValue("midrst_count", min_times.size(), 2);
    checkValue("midrst_first", (min_times.size() > 0) ? min_times[0] - c0 : -1, D + 3);
    checkValue("midrst_after", (min_times.size() > 1) ? min_times[1] - r0 : -1, D + 3);

    $display("[TB] random phase");
    for (int it = 0; it < 60; it++) begin
      logic [2:0] b;
      bit e;
      int dur;
      b   = 3'($urandom);
      e   = ($urandom_range(0, 3) == 0);
      dur = $urandom_range(1, 30);
      applyStimulus(b[0], b[1], b[2], e);
      if (dur > 1) waitCycles(dur - 1);
    end
    applyStimulus(0, 0, 0, 0);
    waitCycles(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
